// File: rtl/mips_multicycle_ctrl.sv
// Main control FSM for the multi-cycle MIPS datapath: Moore-decoded datapath
// controls, memory-ready handshake and a per-state wait watchdog.
module mips_multicycle_ctrl #(
    parameter int unsigned WAIT_LIMIT = 15
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_write,
    output logic       mem_to_reg,
    output logic       reg_dst,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] alu_op,
    output logic [1:0] pc_src,
    output logic       zero_extend,
    output logic       illegal_op,
    output logic       mem_timeout,
    output logic [3:0] state
);

    typedef enum logic [3:0] {
        S_FETCH  = 4'd0,  S_DECODE = 4'd1,  S_MEMADR = 4'd2,  S_MEMRD = 4'd3,
        S_MEMWB  = 4'd4,  S_MEMWR  = 4'd5,  S_EXEC   = 4'd6,  S_ALUWB = 4'd7,
        S_BRANCH = 4'd8,  S_IMMEX  = 4'd9,  S_IMMWB  = 4'd10, S_JUMP  = 4'd11
    } state_t;

    localparam logic [5:0] OP_R    = 6'b000000;
    localparam logic [5:0] OP_LW   = 6'b100011;
    localparam logic [5:0] OP_SW   = 6'b101011;
    localparam logic [5:0] OP_BEQ  = 6'b000100;
    localparam logic [5:0] OP_ADDI = 6'b001000;
    localparam logic [5:0] OP_ANDI = 6'b001100;
    localparam logic [5:0] OP_ORI  = 6'b001101;
    localparam logic [5:0] OP_J    = 6'b000010;
    localparam logic [7:0] W_LIMIT = 8'(WAIT_LIMIT);

    state_t     r_state;
    state_t     w_next;
    logic [5:0] r_op;
    logic [7:0] r_wcnt;
    logic [7:0] w_wcnt_next;
    logic       r_illegal;
    logic       r_timeout;
    logic       w_dec_illegal;
    logic       w_wait_state;
    logic       w_abort;
    logic       w_imm_zx;

    assign w_wait_state = (r_state == S_FETCH) || (r_state == S_MEMRD) || (r_state == S_MEMWR);
    assign w_abort      = w_wait_state && !mem_ready && (W_LIMIT != 8'd0) && (r_wcnt == W_LIMIT);
    assign w_imm_zx     = (r_op == OP_ANDI) || (r_op == OP_ORI);

    assign illegal_op  = r_illegal;
    assign mem_timeout = r_timeout;
    assign state       = r_state;

    // Next-state decode; an abort always lands back in FETCH.
    always_comb begin
        w_next        = S_FETCH;
        w_dec_illegal = 1'b0;
        case (r_state)
            S_FETCH: begin
                if (w_abort)        w_next = S_FETCH;
                else if (mem_ready) w_next = S_DECODE;
                else                w_next = S_FETCH;
            end
            S_DECODE: begin
                case (opcode)
                    OP_R:                    w_next = S_EXEC;
                    OP_LW, OP_SW:            w_next = S_MEMADR;
                    OP_BEQ:                  w_next = S_BRANCH;
                    OP_ADDI, OP_ANDI, OP_ORI: w_next = S_IMMEX;
                    OP_J:                    w_next = S_JUMP;
                    default: begin
                        w_next        = S_FETCH;
                        w_dec_illegal = 1'b1;
                    end
                endcase
            end
            S_MEMADR: begin
                if (r_op == OP_SW) w_next = S_MEMWR;
                else               w_next = S_MEMRD;
            end
            S_MEMRD: begin
                if (w_abort)        w_next = S_FETCH;
                else if (mem_ready) w_next = S_MEMWB;
                else                w_next = S_MEMRD;
            end
            S_MEMWR: begin
                if (w_abort || mem_ready) w_next = S_FETCH;
                else                      w_next = S_MEMWR;
            end
            S_EXEC:  w_next = S_ALUWB;
            S_IMMEX: w_next = S_IMMWB;
            default: w_next = S_FETCH;
        endcase
    end

    // Watchdog counter restarts whenever a state is (re)entered.
    always_comb begin
        w_wcnt_next = r_wcnt;
        if (w_abort || (w_next != r_state)) begin
            w_wcnt_next = 8'd0;
        end else if (w_wait_state && !mem_ready && (r_wcnt != 8'hFF)) begin
            w_wcnt_next = r_wcnt + 8'd1;
        end else begin
            w_wcnt_next = r_wcnt;
        end
    end

    // Moore output decode, held at zero while reset is asserted.
    always_comb begin
        pc_write      = 1'b0;
        pc_write_cond = 1'b0;
        i_or_d        = 1'b0;
        mem_write     = 1'b0;
        ir_write      = 1'b0;
        reg_write     = 1'b0;
        mem_to_reg    = 1'b0;
        reg_dst       = 1'b0;
        alu_src_a     = 1'b0;
        alu_src_b     = 2'b00;
        alu_op        = 2'b00;
        pc_src        = 2'b00;
        zero_extend   = 1'b0;
        if (reset) begin
            pc_write = 1'b0;
        end else begin
            case (r_state)
                S_DECODE: alu_src_b = 2'b11;
                S_MEMADR: begin
                    alu_src_a = 1'b1;
                    alu_src_b = 2'b10;
                end
                S_MEMRD: i_or_d = 1'b1;
                S_MEMWB: begin
                    reg_write  = 1'b1;
                    mem_to_reg = 1'b1;
                end
                S_MEMWR: begin
                    i_or_d    = 1'b1;
                    mem_write = 1'b1;
                end
                S_EXEC: begin
                    alu_src_a = 1'b1;
                    alu_op    = 2'b10;
                end
                S_ALUWB: begin
                    reg_write = 1'b1;
                    reg_dst   = 1'b1;
                end
                S_BRANCH: begin
                    alu_src_a     = 1'b1;
                    alu_op        = 2'b01;
                    pc_src        = 2'b01;
                    pc_write_cond = 1'b1;
                end
                S_IMMEX: begin
                    alu_src_a   = 1'b1;
                    alu_src_b   = 2'b10;
                    alu_op      = w_imm_zx ? 2'b11 : 2'b00;
                    zero_extend = w_imm_zx;
                end
                S_IMMWB: begin
                    reg_write   = 1'b1;
                    zero_extend = w_imm_zx;
                end
                S_JUMP: begin
                    pc_src   = 2'b10;
                    pc_write = 1'b1;
                end
                // FETCH and the unused encodings 12-15
                default: begin
                    alu_src_b = 2'b01;
                    ir_write  = mem_ready;
                    pc_write  = mem_ready;
                end
            endcase
        end
    end

    // State, latched opcode, watchdog and event pulse registers.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state   <= S_FETCH;
            r_op      <= 6'd0;
            r_wcnt    <= 8'd0;
            r_illegal <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_next;
            if (r_state == S_DECODE) r_op <= opcode;
            r_wcnt    <= w_wcnt_next;
            r_illegal <= w_dec_illegal;
            r_timeout <= w_abort;
        end
    end

endmodule

// File: tb/tb_mips_multicycle_ctrl.sv
// Self-checking bench for mips_multicycle_ctrl: table of per-cycle vectors fed
// through a scoreboard queue, plus reset and watchdog sequences.
module tb_mips_multicycle_ctrl;

    logic       clk = 1'b0;
    logic       reset;
    logic [5:0] opcode;
    logic       mem_ready;
    logic       pc_write, pc_write_cond, i_or_d, mem_write, ir_write, reg_write;
    logic       mem_to_reg, reg_dst, alu_src_a, zero_extend, illegal_op, mem_timeout;
    logic [1:0] alu_src_b, alu_op, pc_src;
    logic [3:0] state;

    always #5 clk = ~clk;

    mips_multicycle_ctrl #(.WAIT_LIMIT(4)) dut (
        .clk(clk), .reset(reset), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(pc_write), .pc_write_cond(pc_write_cond), .i_or_d(i_or_d),
        .mem_write(mem_write), .ir_write(ir_write), .reg_write(reg_write),
        .mem_to_reg(mem_to_reg), .reg_dst(reg_dst), .alu_src_a(alu_src_a),
        .alu_src_b(alu_src_b), .alu_op(alu_op), .pc_src(pc_src),
        .zero_extend(zero_extend), .illegal_op(illegal_op),
        .mem_timeout(mem_timeout), .state(state)
    );

    typedef struct packed {
        logic [3:0] st;
        logic       pcw, pcwc, iord, mw, irw, rw, m2r, rdst, asa;
        logic [1:0] asb, aop, psrc;
        logic       ze, ill, to;
    } outs_t;

    typedef struct {
        logic [5:0] op;
        logic       rdy;
        outs_t      exp;
    } vec_t;

    vec_t  vecs[$];
    outs_t sb_q[$];
    int    n_cmp = 0;
    int    n_bad = 0;

    outs_t E_F1, E_F0, E_D, E_MA, E_MR, E_MWB, E_MW, E_EX, E_AWB, E_BR;
    outs_t E_IXA, E_IXL, E_IWA, E_IWL, E_J, E_FILL, E_FTO;

    function automatic outs_t mk(input logic [3:0] st, input logic pcw, pcwc, iord, mw, irw,
                                 rw, m2r, rdst, asa, input logic [1:0] asb, aop, psrc,
                                 input logic ze);
        outs_t o;
        o = '{st: st, pcw: pcw, pcwc: pcwc, iord: iord, mw: mw, irw: irw, rw: rw, m2r: m2r,
              rdst: rdst, asa: asa, asb: asb, aop: aop, psrc: psrc, ze: ze, ill: 1'b0, to: 1'b0};
        return o;
    endfunction

    function automatic outs_t cur();
        outs_t o;
        o = '{st: state, pcw: pc_write, pcwc: pc_write_cond, iord: i_or_d, mw: mem_write,
              irw: ir_write, rw: reg_write, m2r: mem_to_reg, rdst: reg_dst, asa: alu_src_a,
              asb: alu_src_b, aop: alu_op, psrc: pc_src, ze: zero_extend, ill: illegal_op,
              to: mem_timeout};
        return o;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic add(input logic [5:0] op, input logic rdy, input outs_t e);
        vec_t v;
        v.op  = op;
        v.rdy = rdy;
        v.exp = e;
        vecs.push_back(v);
    endtask

    // Drive one cycle's inputs, queue its expectation, compare at the falling edge.
    task automatic apply(input vec_t v, input int idx);
        outs_t e;
        opcode    = v.op;
        mem_ready = v.rdy;
        sb_q.push_back(v.exp);
        @(negedge clk);
        if (sb_q.size() == 0) begin
            check($sformatf("vec%0d_queue_empty", idx), 32'd1, 32'd0);
        end else begin
            e = sb_q.pop_front();
            check($sformatf("vec%0d_op%b", idx, v.op), 32'(cur()), 32'(e));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL global_timeout: got running expected finished");
        $fatal(1);
    end

    initial begin
        int    t_at;
        logic  irw_seen;
        logic  [31:0] to_hist;
        vec_t  v;

        E_F1  = mk(4'd0,  1,0,0,0,1,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
        E_F0  = mk(4'd0,  0,0,0,0,0,0,0,0,0, 2'b01, 2'b00, 2'b00, 0);
        E_D   = mk(4'd1,  0,0,0,0,0,0,0,0,0, 2'b11, 2'b00, 2'b00, 0);
        E_MA  = mk(4'd2,  0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
        E_MR  = mk(4'd3,  0,0,1,0,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        E_MWB = mk(4'd4,  0,0,0,0,0,1,1,0,0, 2'b00, 2'b00, 2'b00, 0);
        E_MW  = mk(4'd5,  0,0,1,1,0,0,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        E_EX  = mk(4'd6,  0,0,0,0,0,0,0,0,1, 2'b00, 2'b10, 2'b00, 0);
        E_AWB = mk(4'd7,  0,0,0,0,0,1,0,1,0, 2'b00, 2'b00, 2'b00, 0);
        E_BR  = mk(4'd8,  0,1,0,0,0,0,0,0,1, 2'b00, 2'b01, 2'b01, 0);
        E_IXA = mk(4'd9,  0,0,0,0,0,0,0,0,1, 2'b10, 2'b00, 2'b00, 0);
        E_IXL = mk(4'd9,  0,0,0,0,0,0,0,0,1, 2'b10, 2'b11, 2'b00, 1);
        E_IWA = mk(4'd10, 0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 0);
        E_IWL = mk(4'd10, 0,0,0,0,0,1,0,0,0, 2'b00, 2'b00, 2'b00, 1);
        E_J   = mk(4'd11, 1,0,0,0,0,0,0,0,0, 2'b00, 2'b00, 2'b10, 0);
        E_FILL = E_F0; E_FILL.ill = 1'b1;
        E_FTO  = E_F0; E_FTO.to   = 1'b1;

        // R, ori, addi, andi
        add(6'b000000,1,E_F1); add(6'b000000,1,E_D); add(6'b000000,1,E_EX); add(6'b000000,1,E_AWB);
        add(6'b001101,1,E_F1); add(6'b001101,1,E_D); add(6'b001101,1,E_IXL); add(6'b001101,1,E_IWL);
        add(6'b001000,1,E_F1); add(6'b001000,1,E_D); add(6'b001000,1,E_IXA); add(6'b001000,1,E_IWA);
        add(6'b001100,1,E_F1); add(6'b001100,1,E_D); add(6'b001100,1,E_IXL); add(6'b001100,1,E_IWL);
        // lw with three wait cycles in MEMRD, then sw with one
        add(6'b100011,1,E_F1); add(6'b100011,1,E_D); add(6'b100011,1,E_MA);
        add(6'b100011,0,E_MR); add(6'b100011,0,E_MR); add(6'b100011,0,E_MR);
        add(6'b100011,1,E_MR); add(6'b100011,1,E_MWB);
        add(6'b101011,1,E_F1); add(6'b101011,1,E_D); add(6'b101011,1,E_MA);
        add(6'b101011,0,E_MW); add(6'b101011,1,E_MW);
        // beq, illegal opcode, j
        add(6'b000100,1,E_F1); add(6'b000100,1,E_D); add(6'b000100,1,E_BR);
        add(6'b111111,1,E_F1); add(6'b111111,1,E_D); add(6'b111111,0,E_FILL);
        add(6'b000010,1,E_F1); add(6'b000010,1,E_D); add(6'b000010,1,E_J);
        // mem_ready arriving exactly at the wait limit completes the fetch
        for (int i = 0; i < 4; i++) add(6'b000100,0,E_F0);
        add(6'b000100,1,E_F1); add(6'b000100,1,E_D); add(6'b000100,1,E_BR);
        // lw stalled in MEMRD past the limit aborts to FETCH
        add(6'b100011,1,E_F1); add(6'b100011,1,E_D); add(6'b100011,1,E_MA);
        for (int i = 0; i < 5; i++) add(6'b100011,0,E_MR);
        add(6'b000000,0,E_FTO); add(6'b000000,1,E_F1); add(6'b000000,1,E_D);
        add(6'b000000,1,E_EX); add(6'b000000,1,E_AWB);

        reset     = 1'b1;
        mem_ready = 1'b1;
        opcode    = 6'd0;
        @(negedge clk);
        check("reset_outs_zero", 32'(cur()), 32'd0);
        @(posedge clk); #1;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            apply(vecs[i], i);
            @(posedge clk); #1;
        end

        // Reset in the middle of a store-wait drops mem_write immediately.
        v.op = 6'b101011; v.rdy = 1'b1; v.exp = E_F1; apply(v, 900); @(posedge clk); #1;
        v.exp = E_D;  apply(v, 901); @(posedge clk); #1;
        v.exp = E_MA; apply(v, 902); @(posedge clk); #1;
        v.rdy = 1'b0; v.exp = E_MW; apply(v, 903);
        #1 reset = 1'b1;
        #1;
        check("async_reset_mem_write", 32'(mem_write), 32'd0);
        check("async_reset_state", 32'(state), 32'd0);
        mem_ready = 1'b0;
        @(posedge clk); #1;
        reset = 1'b0;

        // Watchdog from reset with mem_ready held low.
        t_at     = -1;
        irw_seen = 1'b0;
        to_hist  = 32'd0;
        for (int i = 1; i <= 20; i++) begin
            @(negedge clk);
            if (i == 1) begin
                check("post_reset_alu_src_b", 32'(alu_src_b), 32'd1);
                check("post_reset_state", 32'(state), 32'd0);
            end
            if (ir_write) irw_seen = 1'b1;
            to_hist[i] = mem_timeout;
            if (mem_timeout && (t_at < 0)) t_at = i;
        end
        check("timeout_cycle", 32'(t_at), 32'd6);
        check("timeout_one_cycle", 32'(to_hist[7]), 32'd0);
        check("timeout_no_ir_write", 32'(irw_seen), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/mips_multicycle_ctrl.md
Name: mips_multicycle_ctrl

Overview:
- Moore-style main control FSM for the multi-cycle MIPS datapath.
- Sequences instruction fetch, decode, execute, memory access and writeback over multiple cycles.
- Drives the sign/zero immediate-extend select (zero_extend), ALU operand and operation selects, PC/IR/register/memory write enables.
- Waits on a memory ready handshake, with a watchdog timeout.

Parameters:
- WAIT_LIMIT, 15: maximum cycles spent waiting on mem_ready in one memory state before abort. 0 disables the watchdog. Range 0-255.

Ports:
- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-high reset
- opcode  input  6  instr[31:26] from the IR; sampled only in DECODE
- mem_ready  input  1  memory completes the current access this cycle
- pc_write  output  1  unconditional PC load
- pc_write_cond  output  1  PC load if ALU zero (beq)
- i_or_d  output  1  memory address select: 0=PC, 1=ALUOut
- mem_write  output  1  memory write strobe
- ir_write  output  1  IR load
- reg_write  output  1  register file write
- mem_to_reg  output  1  writeback select: 1=MDR, 0=ALUOut
- reg_dst  output  1  destination select: 1=rd, 0=rt
- alu_src_a  output  1  0=PC, 1=A
- alu_src_b  output  2  00=B, 01=4, 10=ext imm, 11=ext imm<<2
- alu_op  output  2  00=add, 01=sub, 10=funct, 11=logical-imm (by op_q)
- pc_src  output  2  00=ALU, 01=ALUOut, 10=jump target
- zero_extend  output  1  to the immediate extender: 1=zero-extend, 0=sign-extend
- illegal_op  output  1  one-cycle pulse on an unsupported opcode
- mem_timeout  output  1  one-cycle pulse on a watchdog abort
- state  output  4  current state encoding, for debug

Behaviour:
- Reset (asynchronous): state=FETCH, op_q=0, wait counter=0, illegal_op=0, mem_timeout=0. All other outputs are forced 0 while reset is high. Reset mid-instruction abandons it with no write strobes.
- Opcodes: R=000000, lw=100011, sw=101011, beq=000100, addi=001000, andi=001100, ori=001101, j=000010.
- op_q is latched from opcode on the DECODE cycle. All later states decode op_q.
- Unlisted outputs are 0 in each state.
- FETCH(0): i_or_d=0, alu_src_a=0, alu_src_b=01, alu_op=00, pc_src=00.
  - ir_write = pc_write = mem_ready.
  - Stays in FETCH until mem_ready, then goes to DECODE.
- DECODE(1): alu_src_a=0, alu_src_b=11, alu_op=00 (branch target precompute).
  - R goes to EXEC; lw/sw to MEMADR; beq to BRANCH; addi/andi/ori to IMMEX; j to JUMP.
  - Any other opcode goes to FETCH, with illegal_op=1 during that FETCH cycle.
- MEMADR(2): alu_src_a=1, alu_src_b=10, alu_op=00, zero_extend=0. lw goes to MEMRD; sw to MEMWR.
- MEMRD(3): i_or_d=1. Waits for mem_ready, then goes to MEMWB.
- MEMWB(4): reg_write=1, mem_to_reg=1, reg_dst=0. Next: FETCH.
- MEMWR(5): i_or_d=1, mem_write=1. mem_write is held until mem_ready, then FETCH.
- EXEC(6): alu_src_a=1, alu_src_b=00, alu_op=10. Next: ALUWB.
- ALUWB(7): reg_write=1, reg_dst=1, mem_to_reg=0. Next: FETCH.
- BRANCH(8): alu_src_a=1, alu_src_b=00, alu_op=01, pc_src=01, pc_write_cond=1. Next: FETCH.
- IMMEX(9): alu_src_a=1, alu_src_b=10.
  - addi: alu_op=00, zero_extend=0.
  - andi/ori: alu_op=11, zero_extend=1.
  - Next: IMMWB.
- IMMWB(10): reg_write=1, reg_dst=0, mem_to_reg=0. zero_extend is held at its IMMEX value. Next: FETCH.
- JUMP(11): pc_src=10, pc_write=1. Next: FETCH.
- Encodings 12-15: treated as FETCH (outputs as FETCH), next state FETCH.
- Watchdog:
  - An 8-bit counter clears on entry to FETCH/MEMRD/MEMWR. It increments on each cycle in those states with mem_ready=0.
  - If the counter equals WAIT_LIMIT with mem_ready=0 (WAIT_LIMIT≠0), the FSM goes to FETCH and pulses mem_timeout for one cycle. It issues no ir_write, pc_write or reg_write.
  - mem_ready on the same cycle as the limit wins: the access completes normally.
- Latency with mem_ready tied high (cycles, FETCH to FETCH): R=4, lw=5, sw=4, beq=3, addi/andi/ori=4, j=3.

Test Plan:
- Reset asserted mid-MEMWR with mem_write=1 -> mem_write drops the same cycle (asynchronous), state=0. After release, FETCH outputs are alu_src_b=01.
- mem_ready=1, opcode=000000 -> states 0,1,6,7,0. reg_write=1 and reg_dst=1 only in state 7. ir_write=pc_write=1 in state 0.
- opcode=001101 (ori) -> states 0,1,9,10. zero_extend=1 in states 9 and 10, alu_op=11. Repeat with 001000 (addi) -> zero_extend=0, alu_op=00.
- opcode=100011 (lw), mem_ready low for 3 cycles in MEMRD -> MEMRD is held for 4 cycles, then MEMWB with mem_to_reg=1, reg_write=1.
- WAIT_LIMIT=4, mem_ready=0 from reset -> 4 cycles later the FSM aborts to FETCH with mem_timeout=1 for one cycle, and ir_write never asserts.
- opcode=111111 -> states 0,1,0. illegal_op=1 during the second FETCH only, and there are no write strobes.
